// File: rtl/axi_pkg.sv
// Shared AXI encodings, channel FSM state types and burst-legality helpers
// for the burst memory slave.
package axi_pkg;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      W_IDLE = 2'b00,
      W_DATA = 2'b01,
      W_RESP = 2'b10
   } w_state_t;

   typedef enum logic {
      R_IDLE = 1'b0,
      R_DATA = 1'b1
   } r_state_t;

   // A beat may not be wider than the data bus.
   function automatic logic size_ok(input logic [2:0] size, input int unsigned data_width);
      int unsigned beat_bytes_v;
      beat_bytes_v = 32'd1 << size;
      return (beat_bytes_v <= (data_width / 32'd8));
   endfunction

   // WRAP bursts are only legal with 2, 4, 8 or 16 beats.
   function automatic logic wrap_len_ok(input int unsigned len);
      return (len == 32'd1) || (len == 32'd3) || (len == 32'd7) || (len == 32'd15);
   endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational AXI beat address helper: next beat address for FIXED/INCR/WRAP,
// range check of the current address, RAM word index, and burst-legality error.
module axi_burst_addr_gen
   import axi_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_WORDS  = 128,
   parameter int LEN_WIDTH  = 8,
   parameter int BASE_ADDR  = 0,
   parameter int IDX_WIDTH  = $clog2(NUM_WORDS)
) (
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [LEN_WIDTH-1:0]  len,
   input  logic [2:0]            size,
   input  logic [1:0]            burst,
   output logic [ADDR_WIDTH-1:0] next_addr,
   output logic                  in_range,
   output logic                  burst_err,
   output logic [IDX_WIDTH-1:0]  word_idx
);

   localparam int LSB = $clog2(DATA_WIDTH / 8);
   localparam logic [ADDR_WIDTH-1:0] ONE_A   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH-1:0] BASE_A  = ADDR_WIDTH'(BASE_ADDR);
   localparam logic [ADDR_WIDTH-1:0] RANGE_A = ADDR_WIDTH'(NUM_WORDS * (DATA_WIDTH / 8));

   logic [ADDR_WIDTH-1:0] beat_bytes_s;
   logic [ADDR_WIDTH-1:0] size_mask_s;
   logic [ADDR_WIDTH-1:0] incr_s;
   logic [ADDR_WIDTH-1:0] span_mask_s;
   logic [ADDR_WIDTH-1:0] wrap_low_s;
   logic [ADDR_WIDTH-1:0] offset_s;
   logic                  unused_offset_s;

   // Next beat address: align to the beat size, step one beat, fold WRAP back at the span edge.
   always_comb begin
      beat_bytes_s = ONE_A << size;
      size_mask_s  = beat_bytes_s - ONE_A;
      incr_s       = (addr & ~size_mask_s) + beat_bytes_s;
      span_mask_s  = ((ADDR_WIDTH'(len) + ONE_A) << size) - ONE_A;
      wrap_low_s   = addr & ~span_mask_s;
      next_addr    = addr;
      case (burst)
         BURST_FIXED: next_addr = addr;
         BURST_INCR:  next_addr = incr_s;
         BURST_WRAP: begin
            if ((incr_s & ~span_mask_s) != wrap_low_s) begin
               next_addr = wrap_low_s;
            end else begin
               next_addr = incr_s;
            end
         end
         default:     next_addr = addr;
      endcase
   end

   // Range check and word index of the current beat; burst-level legality.
   always_comb begin
      offset_s  = addr - BASE_A;
      in_range  = (addr >= BASE_A) && (offset_s < RANGE_A);
      word_idx  = offset_s[LSB +: IDX_WIDTH];
      burst_err = !size_ok(size, DATA_WIDTH) || (burst == 2'b11) ||
                  ((burst == BURST_WRAP) && !wrap_len_ok(32'(len)));
   end

   assign unused_offset_s = ^offset_s;

endmodule

// File: rtl/axi_burst_mem_slave.sv
// AXI4 burst memory slave: independent write (AW/W/B) and read (AR/R) FSMs
// around a one-write-port, one-read-port word RAM. Reads stream one beat per cycle.
module axi_burst_mem_slave
   import axi_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_WORDS  = 128,
   parameter int LEN_WIDTH  = 8,
   parameter int BASE_ADDR  = 0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [ADDR_WIDTH-1:0]   AWADDR,
   input  logic [LEN_WIDTH-1:0]    AWLEN,
   input  logic [2:0]              AWSIZE,
   input  logic [1:0]              AWBURST,
   input  logic                    AWVALID,
   output logic                    AWREADY,
   input  logic [DATA_WIDTH-1:0]   WDATA,
   input  logic [DATA_WIDTH/8-1:0] WSTRB,
   input  logic                    WLAST,
   input  logic                    WVALID,
   output logic                    WREADY,
   output logic [1:0]              BRESP,
   output logic                    BVALID,
   input  logic                    BREADY,
   input  logic [ADDR_WIDTH-1:0]   ARADDR,
   input  logic [LEN_WIDTH-1:0]    ARLEN,
   input  logic [2:0]              ARSIZE,
   input  logic [1:0]              ARBURST,
   input  logic                    ARVALID,
   output logic                    ARREADY,
   output logic [DATA_WIDTH-1:0]   RDATA,
   output logic [1:0]              RRESP,
   output logic                    RLAST,
   output logic                    RVALID,
   input  logic                    RREADY
);

   localparam int IDX_WIDTH = $clog2(NUM_WORDS);
   localparam int NUM_LANES = DATA_WIDTH / 8;
   localparam logic [LEN_WIDTH-1:0] LEN_ONE = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

   logic [DATA_WIDTH-1:0] mem_r [NUM_WORDS];

   // ---------------- write channel ----------------
   w_state_t              w_state_r, w_state_nxt_s;
   logic [ADDR_WIDTH-1:0] aw_addr_r;
   logic [LEN_WIDTH-1:0]  aw_len_r, w_cnt_r;
   logic [2:0]            aw_size_r;
   logic [1:0]            aw_burst_r;
   logic                  w_err_r, bvalid_r;
   logic [1:0]            bresp_r;
   logic [ADDR_WIDTH-1:0] w_next_addr_s;
   logic                  w_in_range_s, w_burst_err_s;
   logic [IDX_WIDTH-1:0]  w_idx_s;
   logic                  aw_hs_s, w_hs_s, b_hs_s, w_last_beat_s, w_beat_err_s, w_last_err_s, w_mem_we_s;

   axi_burst_addr_gen #(
      .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .NUM_WORDS(NUM_WORDS),
      .LEN_WIDTH(LEN_WIDTH), .BASE_ADDR(BASE_ADDR), .IDX_WIDTH(IDX_WIDTH)
   ) u_w_addr_gen (
      .addr(aw_addr_r), .len(aw_len_r), .size(aw_size_r), .burst(aw_burst_r),
      .next_addr(w_next_addr_s), .in_range(w_in_range_s), .burst_err(w_burst_err_s), .word_idx(w_idx_s)
   );

   assign AWREADY       = (w_state_r == W_IDLE);
   assign WREADY        = (w_state_r == W_DATA);
   assign aw_hs_s       = AWVALID && (w_state_r == W_IDLE);
   assign w_hs_s        = WVALID && (w_state_r == W_DATA);
   assign b_hs_s        = bvalid_r && BREADY;
   assign w_last_beat_s = (w_cnt_r == aw_len_r);
   assign w_beat_err_s  = w_burst_err_s || !w_in_range_s;
   assign w_last_err_s  = (WLAST != w_last_beat_s);
   assign w_mem_we_s    = w_hs_s && !w_beat_err_s && !rst;

   // Write FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         w_state_r <= W_IDLE;
      end else begin
         w_state_r <= w_state_nxt_s;
      end
   end

   // Write FSM next state: address, data beats until count reaches len, then response.
   always_comb begin
      w_state_nxt_s = w_state_r;
      case (w_state_r)
         W_IDLE: if (aw_hs_s) w_state_nxt_s = W_DATA; else w_state_nxt_s = W_IDLE;
         W_DATA: if (w_hs_s && w_last_beat_s) w_state_nxt_s = W_RESP; else w_state_nxt_s = W_DATA;
         W_RESP: if (b_hs_s) w_state_nxt_s = W_IDLE; else w_state_nxt_s = W_RESP;
         default: w_state_nxt_s = W_IDLE;
      endcase
   end

   // Write burst context, beat counter, sticky error and B channel registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         aw_addr_r  <= {ADDR_WIDTH{1'b0}};
         aw_len_r   <= {LEN_WIDTH{1'b0}};
         aw_size_r  <= 3'd0;
         aw_burst_r <= BURST_FIXED;
         w_cnt_r    <= {LEN_WIDTH{1'b0}};
         w_err_r    <= 1'b0;
         bvalid_r   <= 1'b0;
         bresp_r    <= RESP_OKAY;
      end else if (aw_hs_s) begin
         aw_addr_r  <= AWADDR;
         aw_len_r   <= AWLEN;
         aw_size_r  <= AWSIZE;
         aw_burst_r <= AWBURST;
         w_cnt_r    <= {LEN_WIDTH{1'b0}};
         w_err_r    <= 1'b0;
      end else if (w_hs_s) begin
         if (w_last_beat_s) begin
            bvalid_r <= 1'b1;
            bresp_r  <= (w_err_r || w_beat_err_s || w_last_err_s) ? RESP_SLVERR : RESP_OKAY;
         end else begin
            aw_addr_r <= w_next_addr_s;
            w_cnt_r   <= w_cnt_r + LEN_ONE;
            w_err_r   <= w_err_r || w_beat_err_s || w_last_err_s;
         end
      end else if (b_hs_s) begin
         bvalid_r <= 1'b0;
      end
   end

   // RAM write port: byte lanes taken straight from WSTRB; contents survive reset.
   always_ff @(posedge clk) begin
      if (w_mem_we_s) begin
         for (int b = 0; b < NUM_LANES; b++) begin
            if (WSTRB[b]) begin
               mem_r[w_idx_s][8*b +: 8] <= WDATA[8*b +: 8];
            end
         end
      end
   end

   assign BVALID = bvalid_r;
   assign BRESP  = bresp_r;

   // ---------------- read channel ----------------
   r_state_t              r_state_r, r_state_nxt_s;
   logic [ADDR_WIDTH-1:0] r_next_r;
   logic [LEN_WIDTH-1:0]  ar_len_r, r_cnt_r;
   logic [2:0]            ar_size_r;
   logic [1:0]            ar_burst_r;
   logic                  rvalid_r, rlast_r;
   logic [1:0]            rresp_r;
   logic [DATA_WIDTH-1:0] rdata_r;
   logic [ADDR_WIDTH-1:0] r_gen_addr_s, r_next_addr_s;
   logic [LEN_WIDTH-1:0]  r_gen_len_s;
   logic [2:0]            r_gen_size_s;
   logic [1:0]            r_gen_burst_s;
   logic                  r_in_range_s, r_burst_err_s, r_beat_err_s;
   logic [IDX_WIDTH-1:0]  r_idx_s;
   logic                  ar_hs_s, r_hs_s, r_load_s;

   // Address generator sees the AR request while idle, then the pending next-beat address.
   always_comb begin
      if (r_state_r == R_IDLE) begin
         r_gen_addr_s  = ARADDR;
         r_gen_len_s   = ARLEN;
         r_gen_size_s  = ARSIZE;
         r_gen_burst_s = ARBURST;
      end else begin
         r_gen_addr_s  = r_next_r;
         r_gen_len_s   = ar_len_r;
         r_gen_size_s  = ar_size_r;
         r_gen_burst_s = ar_burst_r;
      end
   end

   axi_burst_addr_gen #(
      .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .NUM_WORDS(NUM_WORDS),
      .LEN_WIDTH(LEN_WIDTH), .BASE_ADDR(BASE_ADDR), .IDX_WIDTH(IDX_WIDTH)
   ) u_r_addr_gen (
      .addr(r_gen_addr_s), .len(r_gen_len_s), .size(r_gen_size_s), .burst(r_gen_burst_s),
      .next_addr(r_next_addr_s), .in_range(r_in_range_s), .burst_err(r_burst_err_s), .word_idx(r_idx_s)
   );

   assign ARREADY      = (r_state_r == R_IDLE);
   assign ar_hs_s      = ARVALID && (r_state_r == R_IDLE);
   assign r_hs_s       = rvalid_r && RREADY;
   assign r_load_s     = ar_hs_s || (r_hs_s && !rlast_r);
   assign r_beat_err_s = r_burst_err_s || !r_in_range_s;

   // Read FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state_r <= R_IDLE;
      end else begin
         r_state_r <= r_state_nxt_s;
      end
   end

   // Read FSM next state: stream beats until the last one is accepted.
   always_comb begin
      r_state_nxt_s = r_state_r;
      case (r_state_r)
         R_IDLE: if (ar_hs_s) r_state_nxt_s = R_DATA; else r_state_nxt_s = R_IDLE;
         R_DATA: if (r_hs_s && rlast_r) r_state_nxt_s = R_IDLE; else r_state_nxt_s = R_DATA;
         default: r_state_nxt_s = R_IDLE;
      endcase
   end

   // Read burst context and R channel registers; a beat loads on AR accept or on each non-last R accept.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_next_r   <= {ADDR_WIDTH{1'b0}};
         ar_len_r   <= {LEN_WIDTH{1'b0}};
         ar_size_r  <= 3'd0;
         ar_burst_r <= BURST_FIXED;
         r_cnt_r    <= {LEN_WIDTH{1'b0}};
         rvalid_r   <= 1'b0;
         rlast_r    <= 1'b0;
         rresp_r    <= RESP_OKAY;
         rdata_r    <= {DATA_WIDTH{1'b0}};
      end else if (r_load_s) begin
         rvalid_r <= 1'b1;
         r_next_r <= r_next_addr_s;
         rresp_r  <= r_beat_err_s ? RESP_SLVERR : RESP_OKAY;
         rdata_r  <= r_beat_err_s ? {DATA_WIDTH{1'b0}} : mem_r[r_idx_s];
         if (ar_hs_s) begin
            ar_len_r   <= ARLEN;
            ar_size_r  <= ARSIZE;
            ar_burst_r <= ARBURST;
            r_cnt_r    <= {LEN_WIDTH{1'b0}};
            rlast_r    <= (ARLEN == {LEN_WIDTH{1'b0}});
         end else begin
            r_cnt_r <= r_cnt_r + LEN_ONE;
            rlast_r <= ((r_cnt_r + LEN_ONE) == ar_len_r);
         end
      end else if (r_hs_s) begin
         rvalid_r <= 1'b0;
         rlast_r  <= 1'b0;
      end
   end

   assign RVALID = rvalid_r;
   assign RDATA  = rdata_r;
   assign RRESP  = rresp_r;
   assign RLAST  = rlast_r;

endmodule

// File: tb/tb_axi_burst_mem_slave.sv
// Directed bench for axi_burst_mem_slave (32-bit data, 128 words, base 0).
module tb_axi_burst_mem_slave;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] AWADDR, ARADDR, WDATA, RDATA;
   logic [7:0]  AWLEN, ARLEN;
   logic [2:0]  AWSIZE, ARSIZE;
   logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
   logic [3:0]  WSTRB;
   logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
   logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;

   int total = 0;
   int bad   = 0;

   logic [31:0] wd [16];
   logic [3:0]  ws [16];
   logic [31:0] rd [16];
   logic [31:0] rh [16];
   logic [1:0]  rr [16];
   logic        rl [16];
   logic [1:0]  bresp_v;

   axi_burst_mem_slave dut (
      .clk(clk), .rst(rst),
      .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
      .AWVALID(AWVALID), .AWREADY(AWREADY),
      .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
      .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
      .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
      .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Full write burst; early>=0 drives WLAST on that beat instead of the real last one.
   task automatic do_write(input logic [31:0] addr, input int len, input logic [2:0] size,
                           input logic [1:0] burst, input int early, output logic [1:0] resp);
      AWADDR = addr; AWLEN = 8'(len); AWSIZE = size; AWBURST = burst; AWVALID = 1'b1;
      check_eq("awready", {31'd0, AWREADY}, 32'd1);
      @(posedge clk); #1;
      AWVALID = 1'b0;
      for (int i = 0; i <= len; i++) begin
         WDATA = wd[i]; WSTRB = ws[i]; WVALID = 1'b1;
         WLAST = (early >= 0) ? (i == early) : (i == len);
         check_eq("wready", {31'd0, WREADY}, 32'd1);
         @(posedge clk); #1;
      end
      WVALID = 1'b0; WLAST = 1'b0; BREADY = 1'b1;
      check_eq("bvalid", {31'd0, BVALID}, 32'd1);
      resp = BRESP;
      @(posedge clk); #1;
      BREADY = 1'b0;
   endtask

   // Full read burst; hold=1 stalls RREADY one cycle per beat and records the held data in rh.
   task automatic do_read(input logic [31:0] addr, input int len, input logic [2:0] size,
                          input logic [1:0] burst, input bit hold);
      ARADDR = addr; ARLEN = 8'(len); ARSIZE = size; ARBURST = burst; ARVALID = 1'b1;
      check_eq("arready", {31'd0, ARREADY}, 32'd1);
      @(posedge clk); #1;
      ARVALID = 1'b0;
      for (int i = 0; i <= len; i++) begin
         check_eq("rvalid", {31'd0, RVALID}, 32'd1);
         rd[i] = RDATA; rr[i] = RRESP; rl[i] = RLAST;
         if (hold) begin
            RREADY = 1'b0;
            @(posedge clk); #1;
            rh[i] = RDATA;
         end
         RREADY = 1'b1;
         @(posedge clk); #1;
         RREADY = 1'b0;
      end
      check_eq("arready_after", {31'd0, ARREADY}, 32'd1);
   endtask

   initial begin
      rst = 1'b1;
      AWADDR = 32'd0; AWLEN = 8'd0; AWSIZE = 3'd0; AWBURST = 2'd0; AWVALID = 1'b0;
      WDATA = 32'd0; WSTRB = 4'd0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
      ARADDR = 32'd0; ARLEN = 8'd0; ARSIZE = 3'd0; ARBURST = 2'd0; ARVALID = 1'b0; RREADY = 1'b0;
      @(posedge clk); @(posedge clk); #1;

      check_eq("rst_awready", {31'd0, AWREADY}, 32'd1);
      check_eq("rst_wready",  {31'd0, WREADY},  32'd0);
      check_eq("rst_bvalid",  {31'd0, BVALID},  32'd0);
      check_eq("rst_bresp",   {30'd0, BRESP},   32'd0);
      check_eq("rst_arready", {31'd0, ARREADY}, 32'd1);
      check_eq("rst_rvalid",  {31'd0, RVALID},  32'd0);
      check_eq("rst_rlast",   {31'd0, RLAST},   32'd0);
      check_eq("rst_rresp",   {30'd0, RRESP},   32'd0);
      check_eq("rst_rdata",   RDATA,            32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Seed word 0 and word 0x20 with known contents.
      wd[0] = 32'hCAFEF00D; ws[0] = 4'hF;
      do_write(32'h0, 0, 3'd2, 2'b01, -1, bresp_v);
      check_eq("seed0_bresp", {30'd0, bresp_v}, 32'd0);
      wd[0] = 32'h0; ws[0] = 4'hF;
      do_write(32'h20, 0, 3'd2, 2'b01, -1, bresp_v);

      // 1: INCR write 0x10 x4, read back.
      for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; end
      do_write(32'h10, 3, 3'd2, 2'b01, -1, bresp_v);
      check_eq("t1_bresp", {30'd0, bresp_v}, 32'd0);
      do_read(32'h10, 3, 3'd2, 2'b01, 1'b0);
      for (int i = 0; i < 4; i++) begin
         check_eq("t1_rdata", rd[i], 32'(i + 1));
         check_eq("t1_rresp", {30'd0, rr[i]}, 32'd0);
         check_eq("t1_rlast", {31'd0, rl[i]}, (i == 3) ? 32'd1 : 32'd0);
      end

      // 2: WRAP read 0x18 x4 -> words 0x18,0x1C,0x10,0x14 = 3,4,1,2, stalled each beat.
      do_read(32'h18, 3, 3'd2, 2'b10, 1'b1);
      check_eq("t2_d0", rd[0], 32'd3); check_eq("t2_h0", rh[0], 32'd3);
      check_eq("t2_d1", rd[1], 32'd4); check_eq("t2_h1", rh[1], 32'd4);
      check_eq("t2_d2", rd[2], 32'd1); check_eq("t2_h2", rh[2], 32'd1);
      check_eq("t2_d3", rd[3], 32'd2); check_eq("t2_h3", rh[3], 32'd2);
      check_eq("t2_rlast", {31'd0, rl[3]}, 32'd1);

      // 3: FIXED write to 0x20, one byte lane per beat.
      wd[0] = 32'h000000AA; ws[0] = 4'h1;
      wd[1] = 32'h0000BB00; ws[1] = 4'h2;
      wd[2] = 32'h00CC0000; ws[2] = 4'h4;
      do_write(32'h20, 2, 3'd2, 2'b00, -1, bresp_v);
      check_eq("t3_bresp", {30'd0, bresp_v}, 32'd0);
      do_read(32'h20, 0, 3'd2, 2'b01, 1'b0);
      check_eq("t3_rdata", rd[0], 32'h00CCBBAA);

      // 4: INCR crossing the top of memory.
      wd[0] = 32'h11111111; ws[0] = 4'hF;
      wd[1] = 32'h22222222; ws[1] = 4'hF;
      do_write(32'h1FC, 1, 3'd2, 2'b01, -1, bresp_v);
      check_eq("t4_bresp", {30'd0, bresp_v}, 32'd2);
      do_read(32'h1FC, 1, 3'd2, 2'b01, 1'b0);
      check_eq("t4_d0", rd[0], 32'h11111111);
      check_eq("t4_r0", {30'd0, rr[0]}, 32'd0);
      check_eq("t4_d1", rd[1], 32'd0);
      check_eq("t4_r1", {30'd0, rr[1]}, 32'd2);
      do_read(32'h0, 0, 3'd2, 2'b01, 1'b0);
      check_eq("t4_word0", rd[0], 32'hCAFEF00D);

      // 5: illegal bursts and WLAST mismatch.
      do_read(32'h10, 1, 3'd2, 2'b11, 1'b0);
      check_eq("t5a_d0", rd[0], 32'd0); check_eq("t5a_r0", {30'd0, rr[0]}, 32'd2);
      check_eq("t5a_d1", rd[1], 32'd0); check_eq("t5a_r1", {30'd0, rr[1]}, 32'd2);
      do_read(32'h10, 1, 3'd3, 2'b01, 1'b0);
      check_eq("t5b_d0", rd[0], 32'd0); check_eq("t5b_r0", {30'd0, rr[0]}, 32'd2);
      check_eq("t5b_r1", {30'd0, rr[1]}, 32'd2);
      do_read(32'h10, 2, 3'd2, 2'b10, 1'b0);
      check_eq("t5c_r0", {30'd0, rr[0]}, 32'd2);
      check_eq("t5c_d2", rd[2], 32'd0);
      for (int i = 0; i < 4; i++) begin wd[i] = 32'h99; ws[i] = 4'hF; end
      do_write(32'h30, 3, 3'd2, 2'b01, 0, bresp_v);
      check_eq("t5d_bresp", {30'd0, bresp_v}, 32'd2);
      do_write(32'h10, 0, 3'd2, 2'b11, -1, bresp_v);
      check_eq("t5e_bresp", {30'd0, bresp_v}, 32'd2);
      do_read(32'h10, 0, 3'd2, 2'b01, 1'b0);
      check_eq("t5e_kept", rd[0], 32'd1);

      // 6: reset in the middle of concurrent 8-beat write and read.
      AWADDR = 32'h40; AWLEN = 8'd7; AWSIZE = 3'd2; AWBURST = 2'b01; AWVALID = 1'b1;
      ARADDR = 32'h0;  ARLEN = 8'd7; ARSIZE = 3'd2; ARBURST = 2'b01; ARVALID = 1'b1;
      @(posedge clk); #1;
      AWVALID = 1'b0; ARVALID = 1'b0;
      WDATA = 32'h55; WSTRB = 4'hF; WLAST = 1'b0; WVALID = 1'b1; RREADY = 1'b1;
      check_eq("t6_rvalid_busy", {31'd0, RVALID}, 32'd1);
      check_eq("t6_arready_busy", {31'd0, ARREADY}, 32'd0);
      @(posedge clk); #1;
      WVALID = 1'b0; RREADY = 1'b0; rst = 1'b1;
      @(posedge clk); #1;
      check_eq("t6_rvalid",  {31'd0, RVALID},  32'd0);
      check_eq("t6_bvalid",  {31'd0, BVALID},  32'd0);
      check_eq("t6_arready", {31'd0, ARREADY}, 32'd1);
      check_eq("t6_awready", {31'd0, AWREADY}, 32'd1);
      check_eq("t6_wready",  {31'd0, WREADY},  32'd0);
      check_eq("t6_rlast",   {31'd0, RLAST},   32'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      do_read(32'h40, 0, 3'd2, 2'b01, 1'b0);
      check_eq("t6_persist40", rd[0], 32'h55);
      do_read(32'h10, 1, 3'd2, 2'b01, 1'b0);
      check_eq("t6_persist10", rd[0], 32'd1);
      check_eq("t6_persist14", rd[1], 32'd2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
